// File: rtl/adc_sched_pkg.sv
// Shared types and helpers for the ADC conversion scheduler.
`default_nettype none

package adc_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam int SETTLE_CW = 8;   // holds SETTLE_CYC up to 255
  localparam int TMO_CW    = 16;  // holds TIMEOUT_CYC up to 65535
  localparam int DISC_CW   = 8;   // holds DISCARD up to 255
  localparam int RR_MAX    = 16;

  // Lowest requesting index at or above ptr, wrapping to 0. Requests above
  // NCH are zero, so rotating over the full 16-bit window wraps correctly.
  function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int ptr);
    logic [RR_MAX-1:0] rot;
    int                pick;
    rot  = 16'({req, req} >> ptr);
    pick = ptr;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      if (rot[i]) pick = (ptr + i) % RR_MAX;
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// Round-robin channel pick with a pointer that advances past each served channel.
`default_nettype none

module rr_arbiter
  import adc_sched_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req_i,
  input  logic                    done_i,
  input  logic [$clog2(NCH)-1:0]  done_idx_i,
  output logic [$clog2(NCH)-1:0]  grant_o,
  output logic                    any_o
);

  localparam int PW = $clog2(NCH);

  logic [PW-1:0] ptr_q, ptr_d;

  assign grant_o = PW'(rr_pick(16'(req_i), int'(ptr_q)));
  assign any_o   = |req_i;

  always_comb begin
    ptr_d = ptr_q;
    if (done_i) begin
      ptr_d = (done_idx_i == PW'(NCH - 1)) ? '0 : done_idx_i + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/adc_conv_sched.sv
// Shares one ADC among NCH requesters: select, settle, enable, discard stale
// samples, capture, and return the code with a one-cycle response pulse.
`default_nettype none

module adc_conv_sched
  import adc_sched_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int NBITS       = 8,
  parameter int SETTLE_CYC  = 2,
  parameter int DISCARD     = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req,
  output logic [NCH-1:0]          resp_valid,
  output logic [NBITS-1:0]        resp_code,
  output logic                    resp_err,
  output logic [$clog2(NCH)-1:0]  ch_sel,
  output logic                    adc_en,
  input  logic                    adc_data_ready,
  input  logic [NBITS-1:0]        adc_q,
  output logic                    busy
);

  localparam int CW = $clog2(NCH);

  state_e               state_q, state_d;
  logic [CW-1:0]        ch_sel_q, ch_sel_d;
  logic                 adc_en_q, adc_en_d;
  logic [SETTLE_CW-1:0] settle_q, settle_d;
  logic [TMO_CW-1:0]    tmo_q, tmo_d;
  logic [DISC_CW-1:0]   disc_q, disc_d;
  logic [NBITS-1:0]     code_q, code_d;
  logic                 err_q, err_d;
  logic [NCH-1:0]       valid_q, valid_d;

  logic [CW-1:0]        grant;
  logic                 any_req;
  logic                 sample_hit;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .done_i     (state_q == S_DONE),
    .done_idx_i (ch_sel_q),
    .grant_o    (grant),
    .any_o      (any_req)
  );

  assign sample_hit = adc_en_q && adc_data_ready;

  always_comb begin
    state_d  = state_q;
    ch_sel_d = ch_sel_q;
    adc_en_d = 1'b0;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    disc_d   = disc_q;
    code_d   = code_q;
    err_d    = err_q;
    valid_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          ch_sel_d = grant;
          settle_d = '0;
          tmo_d    = '0;
          disc_d   = '0;
          state_d  = (SETTLE_CYC == 0) ? S_CONVERT : S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (int'(settle_q) + 1 >= SETTLE_CYC) state_d  = S_CONVERT;
        else                                  settle_d = settle_q + 1'b1;
      end

      S_CONVERT: begin
        // Capture is checked first so it wins over a coincident timeout.
        if (sample_hit && int'(disc_q) >= DISCARD) begin
          code_d            = adc_q;
          err_d             = 1'b0;
          valid_d[ch_sel_q] = 1'b1;
          state_d           = S_DONE;
        end else begin
          if (sample_hit) disc_d = disc_q + 1'b1;
          if (int'(tmo_q) + 1 >= TIMEOUT_CYC) begin
            code_d            = '0;
            err_d             = 1'b1;
            valid_d[ch_sel_q] = 1'b1;
            state_d           = S_DONE;
          end else begin
            tmo_d    = tmo_q + 1'b1;
            adc_en_d = 1'b1;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_sel_q <= '0;
      adc_en_q <= 1'b0;
      settle_q <= '0;
      tmo_q    <= '0;
      disc_q   <= '0;
      code_q   <= '0;
      err_q    <= 1'b0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      ch_sel_q <= ch_sel_d;
      adc_en_q <= adc_en_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      disc_q   <= disc_d;
      code_q   <= code_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  assign resp_valid = valid_q;
  assign resp_code  = code_q;
  assign resp_err   = err_q;
  assign ch_sel     = ch_sel_q;
  assign adc_en     = adc_en_q;
  assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_adc_conv_sched.sv
// Directed bench for adc_conv_sched with a behavioural SAR ADC (2.0 V ref, 8 bit).
`default_nettype none

module tb_adc_conv_sched;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] resp_valid;
  logic [7:0] resp_code;
  logic       resp_err;
  logic [1:0] ch_sel;
  logic       adc_en;
  logic       adc_data_ready;
  logic [7:0] adc_q;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  int adc_delay = 0;
  bit adc_stuck = 1'b0;
  int en_cnt    = 0;
  int ch_mv [4] = '{500, 1000, 1500, 1900};

  adc_conv_sched #(
    .NCH(4), .NBITS(8), .SETTLE_CYC(2), .DISCARD(1), .TIMEOUT_CYC(64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .resp_valid     (resp_valid),
    .resp_code      (resp_code),
    .resp_err       (resp_err),
    .ch_sel         (ch_sel),
    .adc_en         (adc_en),
    .adc_data_ready (adc_data_ready),
    .adc_q          (adc_q),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] conv(input int mv);
    int c;
    c = mv * 256 / 2000;
    if (c > 255) c = 255;
    return 8'(c);
  endfunction

  // ADC: first ready sample after enable carries a stale code (8'h5A).
  always @(posedge clk) begin
    if (!adc_en || adc_stuck) begin
      en_cnt         <= 0;
      adc_data_ready <= 1'b0;
      adc_q          <= 'x;
    end else begin
      en_cnt <= en_cnt + 1;
      if (en_cnt >= adc_delay) begin
        adc_data_ready <= 1'b1;
        adc_q          <= (en_cnt == adc_delay) ? 8'h5A : conv(ch_mv[ch_sel]);
      end else begin
        adc_data_ready <= 1'b0;
        adc_q          <= 'x;
      end
    end
  end

  task automatic wait_resp(input int bound, output int ch, output logic [3:0] vld,
                           output logic [7:0] code, output logic err,
                           output int at, output bit ok);
    ok = 1'b0; ch = -1; vld = '0; code = '0; err = 1'b0; at = 0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk);
      if (resp_valid != 4'b0) begin
        ok   = 1'b1;
        vld  = resp_valid;
        code = resp_code;
        err  = resp_err;
        at   = cyc;
        for (int j = 0; j < 4; j++) if (resp_valid[j]) ch = j;
        req = req & ~resp_valid;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (resp_valid !== 4'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0000", resp_valid); end
    n_vec++; if (resp_code !== 8'd0)  begin n_bad++; $display("FAIL reset_code got %0d want 0", resp_code); end
    n_vec++; if (resp_err !== 1'b0)   begin n_bad++; $display("FAIL reset_err got %b want 0", resp_err); end
    n_vec++; if (ch_sel !== 2'd0)     begin n_bad++; $display("FAIL reset_chsel got %0d want 0", ch_sel); end
    n_vec++; if (adc_en !== 1'b0)     begin n_bad++; $display("FAIL reset_adc_en got %b want 0", adc_en); end
    n_vec++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    @(negedge clk);
    req = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_vec++; if (busy !== 1'b1 || ch_sel !== 2'd2) begin n_bad++; $display("FAIL single_grant busy=%b ch_sel=%0d want 1/2", busy, ch_sel); end
      end
      if (k == 3) begin
        n_vec++; if (adc_en !== 1'b0) begin n_bad++; $display("FAIL single_en_early got %b want 0", adc_en); end
      end
      if (k == 4) begin
        n_vec++; if (adc_en !== 1'b1) begin n_bad++; $display("FAIL single_en_on got %b want 1", adc_en); end
      end
      if (k < 7) begin
        n_vec++; if (resp_valid !== 4'b0) begin n_bad++; $display("FAIL single_early_resp k=%0d got %b want 0000", k, resp_valid); end
      end
    end
    n_vec++; if (resp_valid !== 4'b0100) begin n_bad++; $display("FAIL single_valid got %b want 0100", resp_valid); end
    n_vec++; if (resp_code !== 8'd192)   begin n_bad++; $display("FAIL single_code got %0d want 192", resp_code); end
    n_vec++; if (resp_err !== 1'b0)      begin n_bad++; $display("FAIL single_err got %b want 0", resp_err); end
    n_vec++; if (ch_sel !== 2'd2)        begin n_bad++; $display("FAIL single_chsel_done got %0d want 2", ch_sel); end
    req = 4'b0000;
    @(negedge clk);
    n_vec++; if (resp_valid !== 4'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_pulse valid=%b busy=%b want 0000/0", resp_valid, busy); end
  endtask

  task automatic test_round_robin();
    int         exp_ch [6]   = '{0, 1, 2, 3, 0, 2};
    logic [7:0] exp_code [6] = '{8'd64, 8'd128, 8'd192, 8'd243, 8'd64, 8'd192};
    int ch, at, prev_at;
    logic [3:0] vld;
    logic [7:0] code;
    logic err;
    bit ok;
    pulse_reset();
    req = 4'b1111;
    prev_at = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        @(negedge clk);
        req = 4'b0101;
      end
      wait_resp(40, ch, vld, code, err, at, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL rr_resp[%0d] no response within 40 cycles", i); end
      n_vec++; if (vld !== 4'(1 << exp_ch[i])) begin n_bad++; $display("FAIL rr_order[%0d] got %b want ch%0d", i, vld, exp_ch[i]); end
      n_vec++; if (code !== exp_code[i] || err !== 1'b0) begin n_bad++; $display("FAIL rr_code[%0d] got %0d/%b want %0d/0", i, code, err, exp_code[i]); end
      if (i > 0 && i != 4) begin
        n_vec++; if (at - prev_at != 8) begin n_bad++; $display("FAIL rr_gap[%0d] got %0d want 8", i, at - prev_at); end
      end
      @(negedge clk);
      n_vec++; if (resp_valid !== 4'b0) begin n_bad++; $display("FAIL rr_pulse[%0d] got %b want 0000", i, resp_valid); end
      prev_at = at + 1;
      prev_at = at;
    end
  endtask

  task automatic test_adc_delay();
    int ch, at, c0;
    logic [3:0] vld;
    logic [7:0] code;
    logic err;
    bit ok;
    adc_delay = 8;
    @(negedge clk);
    req = 4'b0010; c0 = cyc;
    wait_resp(60, ch, vld, code, err, at, ok);
    n_vec++; if (!ok || vld !== 4'b0010) begin n_bad++; $display("FAIL delay_valid got %b want 0010", vld); end
    n_vec++; if (at - c0 != 15) begin n_bad++; $display("FAIL delay_latency got %0d want 15", at - c0); end
    n_vec++; if (code !== 8'd128 || err !== 1'b0) begin n_bad++; $display("FAIL delay_code got %0d/%b want 128/0", code, err); end
    adc_delay = 0;
  endtask

  task automatic test_timeout();
    int ch, at, c0;
    logic [3:0] vld;
    logic [7:0] code;
    logic err;
    bit ok;
    adc_stuck = 1'b1;
    @(negedge clk);
    req = 4'b1000; c0 = cyc;
    wait_resp(100, ch, vld, code, err, at, ok);
    n_vec++; if (!ok || vld !== 4'b1000) begin n_bad++; $display("FAIL tmo_valid got %b want 1000", vld); end
    n_vec++; if (at - c0 != 67) begin n_bad++; $display("FAIL tmo_latency got %0d want 67", at - c0); end
    n_vec++; if (err !== 1'b1 || code !== 8'd0) begin n_bad++; $display("FAIL tmo_err got %b/%0d want 1/0", err, code); end
    adc_stuck = 1'b0;
    @(negedge clk);
    req = 4'b0001; c0 = cyc;
    wait_resp(40, ch, vld, code, err, at, ok);
    n_vec++; if (!ok || vld !== 4'b0001 || at - c0 != 7) begin n_bad++; $display("FAIL tmo_recover got %b at %0d want 0001 at 7", vld, at - c0); end
    n_vec++; if (code !== 8'd64 || err !== 1'b0) begin n_bad++; $display("FAIL tmo_recover_code got %0d/%b want 64/0", code, err); end
  endtask

  task automatic test_reset_mid_convert();
    int ch, at, c1;
    logic [3:0] vld;
    logic [7:0] code;
    logic err;
    bit ok;
    @(negedge clk);
    req = 4'b0010;
    repeat (4) @(negedge clk);
    n_vec++; if (adc_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_en got %b want 1", adc_en); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (adc_en !== 1'b0 || busy !== 1'b0 || resp_valid !== 4'b0) begin
      n_bad++; $display("FAIL rstmid_after en=%b busy=%b valid=%b want 0/0/0000", adc_en, busy, resp_valid);
    end
    c1 = cyc;
    wait_resp(40, ch, vld, code, err, at, ok);
    n_vec++; if (!ok || vld !== 4'b0010 || at - c1 != 7) begin n_bad++; $display("FAIL rstmid_regrant got %b at %0d want 0010 at 7", vld, at - c1); end
    n_vec++; if (code !== 8'd128 || err !== 1'b0) begin n_bad++; $display("FAIL rstmid_code got %0d/%b want 128/0", code, err); end
  endtask

  task automatic test_drop_req();
    int ch, at, c0;
    logic [3:0] vld;
    logic [7:0] code;
    logic err;
    bit ok;
    pulse_reset();
    req = 4'b1000; c0 = cyc;
    @(negedge clk);
    n_vec++; if (busy !== 1'b1 || ch_sel !== 2'd3) begin n_bad++; $display("FAIL drop_grant busy=%b ch_sel=%0d want 1/3", busy, ch_sel); end
    req = 4'b0011;
    wait_resp(40, ch, vld, code, err, at, ok);
    n_vec++; if (!ok || vld !== 4'b1000 || at - c0 != 7) begin n_bad++; $display("FAIL drop_ch3 got %b at %0d want 1000 at 7", vld, at - c0); end
    n_vec++; if (code !== 8'd243 || err !== 1'b0) begin n_bad++; $display("FAIL drop_ch3_code got %0d/%b want 243/0", code, err); end
    wait_resp(40, ch, vld, code, err, at, ok);
    n_vec++; if (!ok || vld !== 4'b0001 || code !== 8'd64) begin n_bad++; $display("FAIL drop_wrap_ch0 got %b code %0d want 0001 code 64", vld, code); end
    wait_resp(40, ch, vld, code, err, at, ok);
    n_vec++; if (!ok || vld !== 4'b0010 || code !== 8'd128) begin n_bad++; $display("FAIL drop_next_ch1 got %b code %0d want 0010 code 128", vld, code); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_adc_delay();
    test_timeout();
    test_reset_mid_convert();
    test_drop_req();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_conv_sched.md
Name: adc_conv_sched

Overview:
- Round-robin conversion scheduler that shares one SAR-style ADC model among NCH requesters.
- Each requester raises a conversion request. The scheduler then:
  - selects that requester's analog input through an external mux (ch_sel),
  - waits a settle time and drives the ADC enable,
  - discards stale samples and captures the first valid code,
  - returns the code to the requester with a one-cycle response pulse.
- A timeout guards against an ADC that never signals data ready.

Parameters:
NCH, 4, number of requesting channels (2..16)
NBITS, 8, ADC code width; matches the ADC nlevels
SETTLE_CYC, 2, cycles ch_sel is held before adc_en asserts (0 allowed)
DISCARD, 1, data-ready samples dropped before capture (covers the one-cycle-stale code after enable)
TIMEOUT_CYC, 64, max cycles in CONVERT before abort

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req  in  NCH  per-channel conversion request, level; held until its resp_valid
resp_valid  out  NCH  one-hot one-cycle pulse: result for that channel present on resp_code
resp_code  out  NBITS  captured ADC code (all-zero on timeout)
resp_err  out  1  qualifies resp_valid: 1 = timeout abort
ch_sel  out  $clog2(NCH)  analog mux select to ADC v_in
adc_en  out  1  ADC enable
adc_data_ready  in  1  ADC data-ready
adc_q  in  NBITS  ADC output code
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst sampled high at a rising edge) produces: state IDLE; resp_valid=0, resp_code=0, resp_err=0, ch_sel=0, adc_en=0, busy=0; RR pointer=0; counters cleared.
- rst mid-conversion aborts immediately. No response is issued for the aborted request; the requester still holds req and is re-served after reset.
- IDLE:
  - If any req bit is set, grant the lowest index at or above the RR pointer, wrapping at NCH-1 -> 0.
  - Register ch_sel = grant. Go to SETTLE; or to CONVERT if SETTLE_CYC=0.
- SETTLE: hold ch_sel for SETTLE_CYC cycles with adc_en=0, then go to CONVERT.
- CONVERT:
  - adc_en=1 registered; it is first high on the cycle after entry.
  - Count cycles where adc_en=1 and adc_data_ready=1.
    - The first DISCARD such cycles are dropped.
    - The next one captures adc_q into resp_code and goes to DONE.
  - A timeout counter starts at entry. When it reaches TIMEOUT_CYC without capture: resp_code=0, resp_err=1, go to DONE.
  - If capture and timeout occur on the same cycle, capture wins (resp_err=0).
- DONE (1 cycle):
  - adc_en=0; resp_valid[grant]=1 for exactly this cycle.
  - RR pointer = grant+1 mod NCH.
  - Return to IDLE. The next grant can occur on the following cycle, so the minimum IDLE dwell is 1 cycle.
- Arbitration and request rules:
  - req changes during SETTLE/CONVERT/DONE do not affect the current grant.
  - Dropping req of the granted channel mid-conversion does not cancel it; the response is still issued.
  - Simultaneous requests are served strictly round-robin; no channel waits more than NCH conversions.
- ch_sel is stable from SETTLE entry through DONE.
- busy=1 in SETTLE, CONVERT and DONE.
- adc_q is sampled only on the capture cycle. X on adc_q at other times must not propagate to any output.
- Latency with the defaults (SETTLE=2, DISCARD=1, no-delay ADC): req high at cycle 0 -> resp_valid at cycle 7:
  - grant at edge 1;
  - SETTLE edges 2–3;
  - adc_en high from edge 4; data_ready high from edge 5;
  - discard at edge 5, capture at edge 6;
  - resp_valid at edge 7.

Decomposition:
- Package adc_sched_pkg holds:
  - the state enum typedef (IDLE, SETTLE, CONVERT, DONE);
  - the constant localparam widths for the settle and timeout counters;
  - a function rr_pick(req, ptr) returning the next grant index.
- One natural sub-module, rr_arbiter: a parameterised combinational round-robin pick plus a registered pointer update on the DONE strobe. The FSM, counters and capture logic stay in adc_conv_sched.

Test Plan:
- Single request, ADC model without delay: req=4'b0100 with the ADC input at 1.5 V against a 2.0 V reference (NBITS=8) -> ch_sel=2 stable; resp_valid=4'b0100 at cycle 7 after req; resp_code=8'd192; resp_err=0.
- All four req high together, pointer=0 -> responses in order ch0, ch1, ch2, ch3. Then re-raise ch0 and ch2 -> ch0 then ch2. Each response is a one-cycle pulse; no overlap.
- ADC delay plusarg (data_ready appears 8 cycles after enable) -> first data_ready cycle discarded; capture on the second; code correct; resp_err=0.
- adc_data_ready tied 0 -> resp_valid with resp_err=1 and resp_code=0 exactly TIMEOUT_CYC=64 cycles after CONVERT entry; the next request is served normally.
- rst pulsed for 1 cycle mid-CONVERT on ch1 -> the cycle after reset: adc_en=0, busy=0, no resp_valid; ch1 (still requesting) is re-granted and completes.
- Granted ch3 drops req during SETTLE while ch0 raises req -> ch3 still receives resp_valid; ch0 is granted next via pointer wrap 3 -> 0.
